qtree_input_framer: RTL
=======================

QTREE_INPUT_FRAMER -- requirements
Module: qtree_input_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 67, width of one QTree_Bool_t word.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-003 SHALL have parameter NUM_OPS, default 2, operand matrices per frame.
REQ-004 SHALL have parameter CNT_W, default 16, width of per-operand word counters.
REQ-005 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_tdata, input, DATA_W, upstream QTree_Bool_t word.
REQ-008 SHALL have ports s_tvalid/s_tlast, input, 1 each, upstream valid and end-of-operand marker.
REQ-009 SHALL have port s_tready, output, 1, upstream ready.
REQ-010 SHALL have ports m_tdata/m_tvalid/m_tlast, output, DATA_W/1/1, stream to the mMapKron wrapper.
REQ-011 SHALL have port m_tready, input, 1, downstream ready.
REQ-012 SHALL have port op_len, output, NUM_OPS*CNT_W, latched word count per operand, operand 0 in the LSBs.
REQ-013 SHALL have ports frame_done/len_ovf, output, 1 each: one-cycle frame-drained pulse; sticky counter-saturation flag.

Function
REQ-014 SHALL push {s_tlast,s_tdata} into the FIFO when s_tvalid && s_tready.
REQ-015 SHALL drive s_tready = !full && state==RECV, combinationally from registered state.
REQ-016 SHALL drive m_tvalid = !empty, with m_tdata/m_tlast showing the FIFO head (first-word fall-through); pop on m_tvalid && m_tready.
REQ-017 SHALL allow push and pop in the same cycle whenever neither full nor empty blocks them; occupancy is then unchanged.
REQ-018 SHALL NOT push when full (s_tready low) and SHALL NOT pop when empty; pointers wrap modulo DEPTH; an extra occupancy bit distinguishes full from empty.
REQ-019 SHALL keep FSM states RECV, DRAIN, DONE; reset state is RECV with operand index 0.
REQ-020 In RECV, each accepted word SHALL increment word_cnt; on an accepted word with s_tlast, op_len[idx] SHALL latch word_cnt+1, word_cnt SHALL clear, and idx SHALL increment.
REQ-021 When the accepted tlast is for idx==NUM_OPS-1, the FSM SHALL go to DRAIN next cycle and s_tready SHALL be low from that cycle.
REQ-022 In DRAIN, when a pop of a word with m_tlast leaves the FIFO empty, the FSM SHALL go to DONE.
REQ-023 In DONE, frame_done SHALL be 1 for exactly that cycle; the FSM SHALL return to RECV next cycle with idx=0; op_len SHALL hold until overwritten by the next frame.
REQ-024 word_cnt SHALL saturate at 2^CNT_W-1; reaching saturation SHALL set len_ovf, which stays set until reset.
REQ-025 A word with s_tlast on a zero-length operand is impossible; an operand is always >=1 word.

Reset
REQ-026 On aresetn low, asynchronously: pointers, occupancy, word_cnt, idx, op_len, len_ovf, frame_done SHALL clear to 0, and the FSM SHALL enter RECV.
REQ-027 During reset: s_tready=0, m_tvalid=0, m_tlast=0; FIFO contents SHALL be discarded (not cleared); a frame in progress SHALL be lost.
REQ-028 s_tready SHALL first rise in the first cycle after aresetn is sampled high.

Structure
REQ-029 QTree_Bool_t and the DATA_W constant SHALL come from the shared mMapKron package; the block defines no duplicate typedefs.
REQ-030 The FSM state enum SHALL be declared in the same shared package.
REQ-031 Storage SHALL be one sub-module, qtree_fifo (parameterised DATA_W+1 x DEPTH, full/empty outputs); the framer instantiates it once.

Verification
REQ-032 Bench SHALL show: operands of 3 and 5 words, m_tready=1 -> op_len={5,3}, m_tlast on output words 3 and 8, frame_done once, 1 cycle after word 8 pops.
REQ-033 Bench SHALL show: m_tready=0 with 20 words offered -> s_tready falls after 16 accepted; m_tready=1 -> all 20 emerge in order.
REQ-034 Bench SHALL show: random m_tready (50%) with push and pop in the same cycle -> output sequence equals input sequence, occupancy never exceeds 16.
REQ-035 Bench SHALL show: third operand offered after second tlast -> s_tready=0 until frame_done, then accepted as operand 0 of a new frame.
REQ-036 Bench SHALL show: aresetn low mid-operand (4 words queued) -> m_tvalid=0 immediately, op_len=0, and a fresh 1+1-word frame then gives op_len={1,1}.
REQ-037 Bench SHALL show: CNT_W=3, 9-word operand -> len_ovf=1 and op_len[0]=7.

Source files
------------

// File: rtl/mmapkron_pkg.sv
// Shared mMapKron definitions: the QTree_Bool_t word and the input framer FSM states.
package mmapkron_pkg;
   localparam int DATA_W = 67;

   typedef logic [DATA_W-1:0] qtree_bool_t;

   typedef enum logic [1:0] {
      RECV  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } framer_state_e;
endpackage

// File: rtl/qtree_fifo.sv
// First-word fall-through FIFO; pointers carry one extra wrap bit so full and empty differ.
module qtree_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Read/write pointers, advanced only on legal push/pop.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= {(AW+1){1'b0}};
         rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array; contents are not reset, stale entries are unreachable once pointers clear.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/qtree_input_framer.sv
// Buffers a frame of NUM_OPS operand matrices for mMapKron, counting words per operand
// and pulsing frame_done once the frame's final word has left the FIFO.
module qtree_input_framer #(
   parameter int DATA_W  = mmapkron_pkg::DATA_W,
   parameter int DEPTH   = 16,
   parameter int NUM_OPS = 2,
   parameter int CNT_W   = 16
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [DATA_W-1:0]        s_tdata,
   input  logic                     s_tvalid,
   input  logic                     s_tlast,
   output logic                     s_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tvalid,
   output logic                     m_tlast,
   input  logic                     m_tready,
   output logic [NUM_OPS*CNT_W-1:0] op_len,
   output logic                     frame_done,
   output logic                     len_ovf
);
   import mmapkron_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);

   framer_state_e                  state;
   framer_state_e                  state_nxt;
   logic [IDX_W-1:0]               idx;
   logic [CNT_W-1:0]               word_cnt;
   logic [CNT_W-1:0]               cnt_inc;
   logic [NUM_OPS-1:0][CNT_W-1:0]  op_len_q;
   logic                           run;
   logic                           push;
   logic                           pop;
   logic                           full;
   logic                           empty;
   logic [AW:0]                    level;
   logic [DATA_W:0]                head;

   // run holds s_tready low through reset and for the cycle in which reset is released.
   assign s_tready = run && !full && (state == RECV);
   assign m_tvalid = !empty;
   assign m_tdata  = head[DATA_W-1:0];
   assign m_tlast  = !empty && head[DATA_W];
   assign push     = s_tvalid && s_tready;
   assign pop      = m_tvalid && m_tready;
   assign cnt_inc  = (word_cnt == CNT_MAX) ? CNT_MAX : (word_cnt + CNT_ONE);
   assign op_len   = op_len_q;

   qtree_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (push),
      .pop     (pop),
      .wdata   ({s_tlast, s_tdata}),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // Next-state decode: frame ends when the final tlast pops with nothing left behind it.
   always_comb begin
      state_nxt = state;
      case (state)
         RECV: begin
            if (push && s_tlast && (idx == LAST_IDX)) state_nxt = DRAIN;
            else                                      state_nxt = RECV;
         end
         DRAIN: begin
            if (pop && m_tlast && (level == LVL_ONE)) state_nxt = DONE;
            else                                      state_nxt = DRAIN;
         end
         DONE:    state_nxt = RECV;
         default: state_nxt = RECV;
      endcase
   end

   // State register, operand bookkeeping and status flags.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= RECV;
         run        <= 1'b0;
         idx        <= {IDX_W{1'b0}};
         word_cnt   <= {CNT_W{1'b0}};
         op_len_q   <= {(NUM_OPS*CNT_W){1'b0}};
         len_ovf    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         run        <= 1'b1;
         state      <= state_nxt;
         frame_done <= (state_nxt == DONE);
         if (state == DONE) begin
            idx <= {IDX_W{1'b0}};
         end else if (push) begin
            if (s_tlast) begin
               op_len_q[idx] <= cnt_inc;
               word_cnt      <= {CNT_W{1'b0}};
               idx           <= (idx == LAST_IDX) ? {IDX_W{1'b0}} : (idx + IDX_ONE);
            end else begin
               word_cnt <= cnt_inc;
            end
            if (cnt_inc == CNT_MAX) len_ovf <= 1'b1;
         end
      end
   end
endmodule
